// File: rtl/host_bus_master.sv
// Initiator for the 16-bit host register bus: turns single read/write requests into
// nCS/nWE/nOE bus cycles with programmable setup, strobe and hold lengths.
module host_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [20:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        HOST_nCS,
  output logic        HOST_nWE,
  output logic        HOST_nOE,
  output logic [20:0] HOST_ADD,
  output logic [15:0] HOST_WDATA,
  input  logic [15:0] HOST_RDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        wr_q, wr_d;
  logic        ncs_d, nwe_d, noe_d;
  logic        rsp_valid_d, busy_d, req_ready_d;
  logic [20:0] add_d;
  logic [15:0] wdata_d, rdata_d;

  // Handshake: a request transfers on a clock edge where req_valid and req_ready are
  // both high; req_ready is high only in IDLE, and req_valid seen while busy is ignored.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    wr_d        = wr_q;
    ncs_d       = HOST_nCS;
    nwe_d       = HOST_nWE;
    noe_d       = HOST_nOE;
    add_d       = HOST_ADD;
    wdata_d     = HOST_WDATA;
    rdata_d     = rsp_rdata;
    rsp_valid_d = 1'b0;
    busy_d      = busy;
    req_ready_d = req_ready;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          wr_d        = req_wr;
          add_d       = req_addr;
          if (req_wr) wdata_d = req_wdata;
          ncs_d       = 1'b0;
          cnt_d       = SETUP_LD;
          state_d     = SETUP;
          busy_d      = 1'b1;
          req_ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          if (wr_q) nwe_d = 1'b0;
          else      noe_d = 1'b0;
          cnt_d   = STROBE_LD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      STROBE: begin
        // Read data is sampled on the edge that ends the strobe, so the responder
        // has had at least one registered clock with nOE low.
        if (cnt == 8'd0) begin
          if (!wr_q) rdata_d = HOST_RDATA;
          nwe_d       = 1'b1;
          noe_d       = 1'b1;
          cnt_d       = HOLD_LD;
          state_d     = HOLD;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          ncs_d       = 1'b1;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      wr_q       <= 1'b0;
      HOST_nCS   <= 1'b1;
      HOST_nWE   <= 1'b1;
      HOST_nOE   <= 1'b1;
      HOST_ADD   <= 21'd0;
      HOST_WDATA <= 16'd0;
      rsp_rdata  <= 16'd0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      wr_q       <= wr_d;
      HOST_nCS   <= ncs_d;
      HOST_nWE   <= nwe_d;
      HOST_nOE   <= noe_d;
      HOST_ADD   <= add_d;
      HOST_WDATA <= wdata_d;
      rsp_rdata  <= rdata_d;
      rsp_valid  <= rsp_valid_d;
      busy       <= busy_d;
      req_ready  <= req_ready_d;
    end
  end

endmodule

// File: doc/host_bus_master.md
Name: host_bus_master

Overview:
- Initiator side of the 16-bit host register bus (HOST_nCS/HOST_nWE/HOST_nOE/HOST_ADD, write-data and read-data lanes) used by the FPGA device-register block.
- Turns single read or write requests, delivered over a valid/ready handshake, into correctly timed bus cycles with programmable setup, strobe and hold lengths.
- For reads, returns the captured data word.
- Used on-chip to drive the register block in place of the external host, for board self-test and for simulation benches.

Parameters:
- SETUP_CYC, 1, cycles with nCS low and address valid before the strobe asserts (legal range 1..255)
- STROBE_CYC, 3, cycles nWE or nOE is held low (legal range 2..255; 2 is the minimum because the responder registers its read data one clock after nOE falls)
- HOLD_CYC, 1, cycles with nCS low after the strobe deasserts (legal range 1..255)

Ports:
- clk  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  21  bus address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_rdata  out  16  read data; valid when rsp_valid is high after a read
- busy  out  1  transaction in flight
- HOST_nCS  out  1  chip select, active low
- HOST_nWE  out  1  write strobe, active low
- HOST_nOE  out  1  output-enable (read) strobe, active low
- HOST_ADD  out  21  address to the responder
- HOST_WDATA  out  16  write data to the responder's HDI
- HOST_RDATA  in  16  read data from the responder's HDO

Behaviour:
- Clock and reset: the block uses the single clock clk; reset nRESET is asynchronous and active-low. All outputs are registered.
- Reset values:
  - HOST_nCS = HOST_nWE = HOST_nOE = 1
  - HOST_ADD = 0, HOST_WDATA = 0
  - rsp_valid = 0, rsp_rdata = 0
  - busy = 0, req_ready = 1
  - State = IDLE, cycle counter = 0
- FSM states: IDLE, SETUP, STROBE, HOLD. An 8-bit down-counter times each phase.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1: latch req_wr, drive HOST_ADD <= req_addr, and drive HOST_WDATA <= req_wdata if the request is a write (otherwise HOST_WDATA keeps its value).
  - On the same edge: HOST_nCS <= 0, load counter = SETUP_CYC-1, go to SETUP, busy <= 1, req_ready <= 0.
- SETUP:
  - nCS = 0, nWE = nOE = 1.
  - When the counter reaches 0: assert HOST_nWE <= 0 for a write or HOST_nOE <= 0 for a read, load STROBE_CYC-1, go to STROBE.
- STROBE:
  - Exactly one strobe is low; nWE and nOE are never low simultaneously.
  - When the counter reaches 0, on that edge:
    - reads only: rsp_rdata <= HOST_RDATA;
    - deassert the strobe, load HOLD_CYC-1, go to HOLD, rsp_valid <= 1.
- HOLD:
  - rsp_valid = 1 only in the first HOLD cycle.
  - nCS stays 0 and both strobes are 1.
  - When the counter reaches 0: HOST_nCS <= 1, busy <= 0, req_ready <= 1, go to IDLE.
- Timing:
  - nCS is low for SETUP_CYC + STROBE_CYC + HOLD_CYC cycles.
  - At least one nCS-high IDLE cycle separates back-to-back transactions.
  - Request-accept edge to rsp_valid = SETUP_CYC + STROBE_CYC cycles.
- Outputs between transactions: HOST_ADD and HOST_WDATA hold their last values. rsp_rdata holds until the next read completes; writes do not change it.
- req_valid while busy: ignored. The block does not queue; the requester must hold req_valid until it sees req_ready.
- Write side effects: the responder samples a write on every nWE-low clock, so a write lands STROBE_CYC times with identical data. This is intended.
- Reset mid-transaction: all strobes and nCS go high immediately (asynchronously), the in-flight request is dropped, and no rsp_valid is issued.

Test Plan:
- Write, default parameters: addr 0x00020, data 0x0015 -> nCS low 5 cycles; nWE low cycles 2-4; nOE stays high; register 0x00020 reads back 0x0015; rsp_valid pulses 4 cycles after accept; req_ready low 5 cycles.
- Read: responder register 0x00010 preloaded 0x05A5; read of 0x00010 -> nOE low 3 cycles; rsp_rdata = 0x05A5 with rsp_valid; nWE never low.
- Back-to-back: req_valid held high with write 0x00072 = 0x000F then read 0x00072 -> one nCS-high cycle between transactions; read returns 0x000F; two rsp_valid pulses.
- Minimum timing: SETUP = 1, STROBE = 2, HOLD = 1, read of a register holding 0x1234 -> correct data captured; nCS low exactly 4 cycles.
- Reset mid-strobe: assert nRESET low during the 2nd STROBE cycle of a write -> nCS/nWE/nOE high with no clock edge; no rsp_valid; req_ready = 1 after release.
- Request while busy: pulse a second req_valid during STROBE -> request ignored; only one transaction appears on the bus.
